// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter and sequencer that shares one iterative RV32M multiply/divide
// unit among NUM_REQ execute stages, returning each result to its owner.
module muldiv_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned OP_W      = 3
) (
  input  logic                           i_aclk,
  input  logic                           i_areset_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*OP_W-1:0]        i_op,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   i_op_a,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   i_op_b,
  input  logic [NUM_REQ-1:0]             i_flush,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic [NUM_REQ-1:0]             o_done,
  output logic [DATA_SIZE-1:0]           o_result,
  output logic                           o_mdu_start,
  output logic [OP_W-1:0]                o_mdu_op,
  output logic [DATA_SIZE-1:0]           o_mdu_a,
  output logic [DATA_SIZE-1:0]           o_mdu_b,
  input  logic                           i_mdu_done,
  input  logic [DATA_SIZE-1:0]           i_mdu_result
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic                   kill_q, kill_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   start_q, start_d;
  logic [DATA_SIZE-1:0]   result_q, result_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [DATA_SIZE-1:0]   a_q, a_d;
  logic [DATA_SIZE-1:0]   b_q, b_d;

  logic [NUM_REQ-1:0]     elig_c;
  logic                   gnt_vld_c;
  logic [PTR_W-1:0]       gnt_idx_c;
  logic [PTR_W-1:0]       rr_next_c;
  logic [OP_W-1:0]        sel_op_c;
  logic [DATA_SIZE-1:0]   sel_a_c;
  logic [DATA_SIZE-1:0]   sel_b_c;
  logic                   owner_flush_c;
  logic                   kill_now_c;

  // Round-robin pick: first eligible requester at or above rr_ptr, wrapping.
  always_comb begin : arb_c
    elig_c    = i_req & ~i_flush;
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!gnt_vld_c && elig_c[j] &&
            (((int'(rr_ptr_q) + i) % int'(NUM_REQ)) == j)) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = PTR_W'(j);
        end
      end
    end
    rr_next_c = PTR_W'((int'(gnt_idx_c) + 1) % int'(NUM_REQ));
  end

  // Operand slice of the winner and flush bit of the current owner.
  always_comb begin : sel_c
    sel_op_c      = '0;
    sel_a_c       = '0;
    sel_b_c       = '0;
    owner_flush_c = 1'b0;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      if (gnt_idx_c == PTR_W'(r)) begin
        sel_op_c = i_op[r*OP_W +: OP_W];
        sel_a_c  = i_op_a[r*DATA_SIZE +: DATA_SIZE];
        sel_b_c  = i_op_b[r*DATA_SIZE +: DATA_SIZE];
      end
      if (owner_q == PTR_W'(r)) begin
        owner_flush_c = i_flush[r];
      end
    end
  end

  always_comb begin : fsm_c
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    kill_d     = kill_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    ack_d      = '0;
    done_d     = '0;
    start_d    = 1'b0;
    kill_now_c = kill_q | owner_flush_c;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_c) begin
          owner_d  = gnt_idx_c;
          op_d     = sel_op_c;
          a_d      = sel_a_c;
          b_d      = sel_b_c;
          kill_d   = 1'b0;
          rr_ptr_d = rr_next_c;
          for (int r = 0; r < int'(NUM_REQ); r++) begin
            ack_d[r] = (gnt_idx_c == PTR_W'(r));
          end
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Start is registered, so the MDU sees it in the first WAIT cycle.
        start_d = 1'b1;
        kill_d  = kill_now_c;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        kill_d = kill_now_c;
        if (i_mdu_done) begin
          if (!kill_now_c) begin
            result_d = i_mdu_result;
          end
          for (int r = 0; r < int'(NUM_REQ); r++) begin
            done_d[r] = !kill_now_c && (owner_q == PTR_W'(r));
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      kill_q   <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      kill_q   <= kill_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      start_q  <= start_d;
      result_q <= result_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_done      = done_q;
  assign o_result    = result_q;
  assign o_mdu_start = start_q;
  assign o_mdu_op    = op_q;
  assign o_mdu_a     = a_q;
  assign o_mdu_b     = b_q;

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative RV32M multiply/divide unit (MDU) among NUM_REQ core execute stages.
- Each execute stage raises a request carrying a funct3 and two operands. The arbiter latches one request, starts the MDU, waits for completion, then returns the result to the owner with a one-cycle done pulse.
- It sits between the per-core execute units and the single shared MDU instance.

Parameters:
NUM_REQ, 4, number of requesting execute stages (2..8)
DATA_SIZE, 32, operand/result width
OP_W, 3, M-extension funct3 width

Ports:
i_aclk  in  1  system clock
i_areset_n  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester request level
i_op  in  NUM_REQ*OP_W  packed funct3; slice r belongs to requester r
i_op_a  in  NUM_REQ*DATA_SIZE  packed operand A (rs1)
i_op_b  in  NUM_REQ*DATA_SIZE  packed operand B (rs2)
i_flush  in  NUM_REQ  per-requester kill of the in-flight op
o_ack  out  NUM_REQ  one-cycle pulse: request latched
o_done  out  NUM_REQ  one-cycle pulse: o_result valid for that requester
o_result  out  DATA_SIZE  registered result, shared bus
o_mdu_start  out  1  one-cycle start strobe to the MDU
o_mdu_op  out  OP_W  latched funct3
o_mdu_a  out  DATA_SIZE  latched operand A
o_mdu_b  out  DATA_SIZE  latched operand B
i_mdu_done  in  1  MDU completion strobe
i_mdu_result  in  DATA_SIZE  MDU result, valid with i_mdu_done

Behaviour:
- Reset (async, i_areset_n low):
  - state=IDLE, rr_ptr=0, owner=0, kill flag=0.
  - o_ack, o_done, o_mdu_start = 0; o_result, o_mdu_op, o_mdu_a, o_mdu_b = 0.
  - Reset mid-operation abandons the transaction; the MDU shares the same reset.
- Requester handshake:
  - Hold i_req[r] and slice r of op/operands stable until o_ack[r].
  - Withdrawing before ack is legal.
  - After ack the inputs are don't-care.
  - i_req[r] high in the cycle after o_done[r] counts as a new request.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch owner, op, a and b; pulse o_ack[owner]; clear the kill flag; set rr_ptr=(owner+1) mod NUM_REQ; go to ISSUE.
  - With no request, stay in IDLE and leave rr_ptr unchanged.
- ISSUE (1 cycle):
  - o_mdu_start=1; o_mdu_op/a/b present the latched values, which stay stable until the next IDLE latch.
  - Go to WAIT.
- WAIT:
  - On i_mdu_done: register i_mdu_result into o_result, unless the kill flag is set, in which case o_result is unchanged. Go to RESP.
  - Otherwise stay in WAIT; there is no timeout.
- RESP (1 cycle):
  - o_done[owner]=1 unless the kill flag is set.
  - Go to IDLE. The owner is not re-granted ahead of other pending requesters because rr_ptr has already advanced.
- Flush:
  - i_flush[owner] in ISSUE or WAIT sets the kill flag. The MDU op still runs to completion; the result is discarded and o_done is suppressed.
  - i_flush[owner] in the RESP cycle is ignored.
  - i_flush on a non-owner is ignored.
  - In IDLE, i_flush[r] masks i_req[r] for arbitration that cycle.
- i_mdu_done outside WAIT is ignored, with no state or output change.
- Latency:
  - Request sampled in IDLE at cycle 0: ack in cycle 0, start in cycle 1.
  - MDU done in cycle 1+k (k≥1) gives o_done in cycle 2+k; minimum 4 cycles from request to done.
  - Next IDLE is cycle 3+k.
- Throughput: at most one op in flight, no pipelining.
- At most one bit of o_ack and one bit of o_done is set per cycle.
- All outputs are registered or decoded from state registers only; no combinational path from i_req to o_mdu_*.

Test Plan:
- Single request: req[2]=1, op=000 (MUL), a=7, b=6, MDU done k=3 cycles after start → ack[2] at cycle 0, start at cycle 1, done[2] with o_result=42 at cycle 5.
- Contention: req=4'b1111 held, rr_ptr=0, each requester drops its req after its ack → ack order 0,1,2,3; each o_done carries that requester's result.
- Fairness: req[1] re-asserted every cycle after its done, req[3] pending → after requester 1 finishes, requester 3 acked before requester 1 again.
- Flush: i_flush[0] during WAIT of owner 0, MDU returns 99 → no o_done pulse, o_result keeps its previous value; the next request is acked normally.
- Reset mid-WAIT: i_areset_n low while in WAIT → all outputs 0 and state IDLE immediately; a later i_mdu_done in IDLE produces no o_done.
- Spurious i_mdu_done=1 with i_mdu_result=5 while in IDLE and no requests → o_result and o_done unchanged.
